// File: rtl/weight_fifo_loader_pkg.sv
// Shared types and default widths for the CNN weight path.
package cnn_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int FIFO_INPUTS = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int ADDR_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } wfl_state_t;
endpackage

// File: rtl/weight_fifo_loader_if.sv
// Weight SRAM read port and weight FIFO push port as seen by the loader.
interface weight_fifo_loader_if #(
    parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
    parameter int FIFO_INPUTS = cnn_pkg::FIFO_INPUTS,
    parameter int ADDR_WIDTH  = cnn_pkg::ADDR_WIDTH,
    localparam int FIFO_WIDTH = DATA_WIDTH * FIFO_INPUTS
);
    logic                   memRdEn;
    logic [ADDR_WIDTH-1:0]  memAddr;
    logic [FIFO_WIDTH-1:0]  memData;
    logic [FIFO_INPUTS-1:0] fifoEn;
    logic [FIFO_WIDTH-1:0]  fifoWeight;

    modport master (
        output memRdEn,
        output memAddr,
        input  memData,
        output fifoEn,
        output fifoWeight
    );

    modport slave (
        input  memRdEn,
        input  memAddr,
        output memData,
        input  fifoEn,
        input  fifoWeight
    );
endinterface

// File: rtl/weight_fifo_loader.sv
// Write-side controller for the systolic array weight FIFO: fetches up to
// FIFO_DEPTH rows from weight SRAM and pushes them, zero-filling the rest.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// FETCH | one row slot per cycle, reads issued for slots below n
// DRAIN | two cycles letting the last pushes leave the pipeline
// DONE  | one-cycle done pulse, start ignored
module weight_fifo_loader
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
    parameter int FIFO_INPUTS = cnn_pkg::FIFO_INPUTS,
    parameter int FIFO_DEPTH  = cnn_pkg::FIFO_DEPTH,
    parameter int ADDR_WIDTH  = cnn_pkg::ADDR_WIDTH,
    localparam int FIFO_WIDTH = DATA_WIDTH * FIFO_INPUTS,
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  baseAddr,
    input  logic [CNT_WIDTH-1:0]   numRows,
    input  logic [FIFO_INPUTS-1:0] colMask,
    weight_fifo_loader_if.master   bus,
    output logic                   busy,
    output logic                   done
);

    wfl_state_t             state, state_next;
    logic [ADDR_WIDTH-1:0]  base_q, base_next;
    logic [FIFO_INPUTS-1:0] mask_q, mask_next;
    logic [CNT_WIDTH-1:0]   n_q, n_next;
    logic [CNT_WIDTH-1:0]   p_q, p_next;
    logic                   drain_q, drain_next;

    logic                   rd_en_q, rd_en_next;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_next;
    logic                   busy_q, busy_next;
    logic                   done_q, done_next;

    logic                   pipe_valid_q;
    logic                   pipe_rd_q;
    logic [FIFO_INPUTS-1:0] fifo_en_q;
    logic [FIFO_WIDTH-1:0]  fifo_weight_q;

    always_comb begin
        state_next = state;
        base_next  = base_q;
        mask_next  = mask_q;
        n_next     = n_q;
        p_next     = p_q;
        drain_next = drain_q;
        rd_en_next = 1'b0;
        addr_next  = addr_q;
        busy_next  = busy_q;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    base_next  = baseAddr;
                    mask_next  = colMask;
                    n_next     = (numRows > CNT_WIDTH'(FIFO_DEPTH)) ?
                                 CNT_WIDTH'(FIFO_DEPTH) : numRows;
                    p_next     = '0;
                    rd_en_next = (n_next != '0);
                    addr_next  = baseAddr;
                    busy_next  = 1'b1;
                end
            end
            FETCH: begin
                if (p_q == CNT_WIDTH'(FIFO_DEPTH - 1)) begin
                    state_next = DRAIN;
                    drain_next = 1'b1;
                end else begin
                    p_next     = p_q + 1'b1;
                    rd_en_next = (p_next < n_q);
                    addr_next  = base_q + ADDR_WIDTH'(p_next);
                end
            end
            DRAIN: begin
                if (drain_q == 1'b0) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    drain_next = drain_q - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            base_q  <= '0;
            mask_q  <= '0;
            n_q     <= '0;
            p_q     <= '0;
            drain_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            base_q  <= base_next;
            mask_q  <= mask_next;
            n_q     <= n_next;
            p_q     <= p_next;
            drain_q <= drain_next;
            rd_en_q <= rd_en_next;
            addr_q  <= addr_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
        end
    end

    // Slot tag follows the read by one cycle, alongside the returning memData.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid_q  <= 1'b0;
            pipe_rd_q     <= 1'b0;
            fifo_en_q     <= '0;
            fifo_weight_q <= '0;
        end else begin
            pipe_valid_q  <= (state == FETCH);
            pipe_rd_q     <= rd_en_q;
            fifo_en_q     <= pipe_valid_q ? mask_q : '0;
            fifo_weight_q <= (pipe_valid_q && pipe_rd_q) ? bus.memData : '0;
        end
    end

    assign bus.memRdEn    = rd_en_q;
    assign bus.memAddr    = addr_q;
    assign bus.fifoEn     = fifo_en_q;
    assign bus.fifoWeight = fifo_weight_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Directed bench for weight_fifo_loader with an SRAM model and a masked shift-FIFO model.
module tb_weight_fifo_loader;

    logic       clock;
    logic       reset;
    logic       start;
    logic [9:0] baseAddr;
    logic [2:0] numRows;
    logic [3:0] colMask;
    logic       busy;
    logic       done;

    int tests;
    int fails;

    weight_fifo_loader_if #(.DATA_WIDTH(8), .FIFO_INPUTS(4), .ADDR_WIDTH(10)) bus ();

    weight_fifo_loader #(
        .DATA_WIDTH (8),
        .FIFO_INPUTS(4),
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (10)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .baseAddr(baseAddr),
        .numRows (numRows),
        .colMask (colMask),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: row a = {4{a[7:0]}}, one cycle latency; junk when not read.
    always @(posedge clock) begin
        if (bus.memRdEn) bus.memData <= {4{bus.memAddr[7:0]}};
        else             bus.memData <= 32'hDEAD_BEEF;
    end

    // Paired FIFO: each enabled column shifts in weightIn; stage 3 is weightOut.
    logic [31:0] stage [4];
    logic        preload_req;
    logic [31:0] preload_val;
    logic [31:0] weight_out;
    assign weight_out = stage[3];

    always @(posedge clock) begin
        if (preload_req) begin
            for (int k = 0; k < 4; k++) stage[k] <= preload_val;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (bus.fifoEn[j]) begin
                    for (int k = 3; k > 0; k--) stage[k][8*j +: 8] <= stage[k-1][8*j +: 8];
                    stage[0][8*j +: 8] <= bus.fifoWeight[8*j +: 8];
                end
            end
        end
    end

    typedef struct {
        logic [9:0]       base;
        logic [2:0]       num;
        logic [3:0]       mask;
        bit               pre;
        logic [31:0]      pre_val;
        int               nreads;
        logic [3:0][9:0]  addr;
        logic [3:0][31:0] rows;
        logic [31:0]      wout;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  reads;
        bit  e_rd;
        logic [3:0]  e_en;
        logic [31:0] e_w;
        if (v.pre) begin
            preload_val = v.pre_val;
            preload_req = 1'b1;
            step();
            preload_req = 1'b0;
        end
        baseAddr = v.base;
        numRows  = v.num;
        colMask  = v.mask;
        start    = 1'b1;
        reads    = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) start = 1'b0;
            e_rd = (c >= 1 && c <= 4 && (c - 1) < v.nreads);
            e_en = (c >= 3 && c <= 6) ? v.mask : 4'b0000;
            e_w  = (c >= 3 && c <= 6) ? v.rows[c-3] : 32'h0;
            chk($sformatf("v%0d c%0d memRdEn", idx, c), 64'(bus.memRdEn), 64'(e_rd));
            if (e_rd && bus.memRdEn)
                chk($sformatf("v%0d c%0d memAddr", idx, c), 64'(bus.memAddr), 64'(v.addr[c-1]));
            chk($sformatf("v%0d c%0d fifoEn", idx, c), 64'(bus.fifoEn), 64'(e_en));
            chk($sformatf("v%0d c%0d fifoWeight", idx, c), 64'(bus.fifoWeight), 64'(e_w));
            chk($sformatf("v%0d c%0d busy", idx, c), 64'(busy), 64'(c >= 1 && c <= 6));
            chk($sformatf("v%0d c%0d done", idx, c), 64'(done), 64'(c == 7));
            if (bus.memRdEn) reads++;
            step();
        end
        chk($sformatf("v%0d read_count", idx), 64'(reads), 64'(v.nreads));
        chk($sformatf("v%0d weightOut", idx), 64'(weight_out), 64'(v.wout));
    endtask

    initial begin
        int reads;
        int dones;

        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        start       = 1'b0;
        baseAddr    = '0;
        numRows     = '0;
        colMask     = '0;
        preload_req = 1'b0;
        preload_val = '0;

        vecs[0] = '{base:10'h010, num:3'd4, mask:4'b1111, pre:1'b0, pre_val:32'h0, nreads:4,
                    addr:{10'h013, 10'h012, 10'h011, 10'h010},
                    rows:{32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010},
                    wout:32'h10101010};
        vecs[1] = '{base:10'h010, num:3'd2, mask:4'b1111, pre:1'b1, pre_val:32'h77777777, nreads:2,
                    addr:{10'h000, 10'h000, 10'h011, 10'h010},
                    rows:{32'h0, 32'h0, 32'h11111111, 32'h10101010},
                    wout:32'h10101010};
        vecs[2] = '{base:10'h3FE, num:3'd7, mask:4'b1111, pre:1'b0, pre_val:32'h0, nreads:4,
                    addr:{10'h001, 10'h000, 10'h3FF, 10'h3FE},
                    rows:{32'h01010101, 32'h00000000, 32'hFFFFFFFF, 32'hFEFEFEFE},
                    wout:32'hFEFEFEFE};
        vecs[3] = '{base:10'h020, num:3'd0, mask:4'b1111, pre:1'b1, pre_val:32'h33333333, nreads:0,
                    addr:{10'h000, 10'h000, 10'h000, 10'h000},
                    rows:{32'h0, 32'h0, 32'h0, 32'h0},
                    wout:32'h00000000};
        vecs[4] = '{base:10'h010, num:3'd4, mask:4'b1010, pre:1'b1, pre_val:32'hAAAAAAAA, nreads:4,
                    addr:{10'h013, 10'h012, 10'h011, 10'h010},
                    rows:{32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010},
                    wout:32'h10AA10AA};
        vecs[5] = '{base:10'h010, num:3'd4, mask:4'b0000, pre:1'b1, pre_val:32'h55555555, nreads:4,
                    addr:{10'h013, 10'h012, 10'h011, 10'h010},
                    rows:{32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010},
                    wout:32'h55555555};

        repeat (3) step();
        chk("reset memRdEn", 64'(bus.memRdEn), 64'(0));
        chk("reset memAddr", 64'(bus.memAddr), 64'(0));
        chk("reset fifoEn", 64'(bus.fifoEn), 64'(0));
        chk("reset fifoWeight", 64'(bus.fifoWeight), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Start while busy (cycle 3) and in the DONE cycle (7) must be ignored.
        baseAddr = 10'h010;
        numRows  = 3'd4;
        colMask  = 4'b1111;
        reads    = 0;
        dones    = 0;
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0 || c == 3 || c == 7);
            if (c == 3) baseAddr = 10'h030;
            if (bus.memRdEn) begin
                reads++;
                chk($sformatf("busy_start c%0d addr_range", c), 64'(bus.memAddr < 10'h030), 64'(1));
            end
            if (done) dones++;
            if (c == 7) chk("busy_start done_cycle", 64'(done), 64'(1));
            if (c == 8) chk("busy_start busy_after_done", 64'(busy), 64'(0));
            if (c == 9) chk("busy_start no_restart", 64'(bus.memRdEn), 64'(0));
            step();
        end
        start = 1'b0;
        chk("busy_start read_count", 64'(reads), 64'(4));
        chk("busy_start done_count", 64'(dones), 64'(1));

        // Reset asserted in cycle 4 of a load.
        baseAddr = 10'h010;
        numRows  = 3'd4;
        colMask  = 4'b1111;
        start    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) start = 1'b0;
            step();
        end
        chk("rst_mid c4 memRdEn", 64'(bus.memRdEn), 64'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid memRdEn", 64'(bus.memRdEn), 64'(0));
        chk("rst_mid memAddr", 64'(bus.memAddr), 64'(0));
        chk("rst_mid fifoEn", 64'(bus.fifoEn), 64'(0));
        chk("rst_mid fifoWeight", 64'(bus.fifoWeight), 64'(0));
        chk("rst_mid busy", 64'(busy), 64'(0));
        chk("rst_mid done", 64'(done), 64'(0));
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dones++;
            if (busy) dones++;
            step();
        end
        chk("rst_mid no_done_or_busy", 64'(dones), 64'(0));
        run_vec(vecs[0], 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
